instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 144 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction-memory loader: receives a byte stream (count header, little-endian
// data words, optional checksum) and writes the words into instruction memory
// while holding the CPU fetch unit.
// Optional feature: define LOADER_CHECKSUM_EN to expect and verify a trailing
// XOR checksum byte.
module instr_mem_loader #(
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned DEPTH = 32'(1) << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, HEADER, DATA, WRITE, CHECK, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [7:0]          remain;
  logic [1:0]          bcnt;
  logic [23:0]         word;
  logic [7:0]          csum;

  // Loader FSM; every output is registered and set together with the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      remain    <= '0;
      bcnt      <= '0;
      word      <= '0;
      csum      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            state    <= HEADER;
            in_ready <= 1'b1;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            load_err <= 1'b0;
          end
        end

        HEADER: begin
          if (in_valid) begin
            remain <= in_data;
            addr   <= ADDR_W'(BASE_ADDR);
            bcnt   <= '0;
            csum   <= '0;
            if (32'(in_data) > DEPTH) load_err <= 1'b1;
            if (in_data == 8'd0) begin
              state    <= CHECK;
              in_ready <= CSUM_EN;
            end else begin
              state <= DATA;
            end
          end
        end

        // Shift bytes in from the top so the first byte ends up in bits [7:0].
        DATA: begin
          if (in_valid) begin
            csum <= csum ^ in_data;
            bcnt <= bcnt + 2'd1;
            word <= {in_data, word[23:8]};
            if (bcnt == 2'd3) begin
              state     <= WRITE;
              in_ready  <= 1'b0;
              mem_we    <= 1'b1;
              mem_waddr <= 32'(addr);
              mem_wdata <= {in_data, word};
            end
          end
        end

        WRITE: begin
          mem_we <= 1'b0;
          addr   <= addr + ADDR_W'(1);
          remain <= remain - 8'd1;
          if (remain == 8'd1) begin
            state    <= CHECK;
            in_ready <= CSUM_EN;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end

        CHECK: begin
          if (!CSUM_EN) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else if (in_valid) begin
            if (in_data != csum) load_err <= 1'b1;
            state     <= DONE;
            in_ready  <= 1'b0;
            load_done <= 1'b1;
          end
        end

        DONE: begin
          state     <= IDLE;
          load_done <= 1'b0;
          cpu_hold  <= 1'b0;
          busy      <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          mem_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (ADDR_W=5, BASE_ADDR=0).
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_hold, busy, load_done, load_err;
  logic [31:0] mem_waddr, mem_wdata;

  int errors = 0;
  int checks = 0;
  int wn = 0;
  int done_cnt = 0;
  logic [31:0] wa [128];
  logic [31:0] wd [128];
  logic [7:0]  tb_csum;

  instr_mem_loader #(.ADDR_W(5), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Write and completion monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && mem_we && wn < 128) begin
      wa[wn] <= mem_waddr;
      wd[wn] <= mem_wdata;
      wn <= wn + 1;
    end
    if (reset && load_done) done_cnt <= done_cnt + 1;
  end

  task automatic idle_bus();
    @(negedge clk);
    in_valid = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    tb_csum = 8'h00;
  endtask

  // Present one byte until accepted; with gap, drop in_valid (and poke load_start) for a cycle.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    @(negedge clk);
    load_start = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_byte_timeout byte=%h in_ready=%b required 1", b, in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (gap) begin
        @(negedge clk);
        in_valid = 1'b0;
        load_start = 1'b1;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      tb_csum = tb_csum ^ b;
      send_byte(b, gap);
    end
  endtask

  task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
    send_byte(tb_csum, 1'b0);
`endif
    idle_bus();
  endtask

  task automatic wait_done(output int t);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!load_done && t < 300);
    checks++;
    if (load_done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout load_done=%b required 1 after %0d cycles", load_done, t);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    checks++; if (mem_waddr !== 32'h0) begin errors++; $display("FAIL rst_waddr got %h want 0", mem_waddr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    checks++; if (cpu_hold !== 1'b0)   begin errors++; $display("FAIL rst_cpu_hold got %b want 0", cpu_hold); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (load_done !== 1'b0)  begin errors++; $display("FAIL rst_load_done got %b want 0", load_done); end
    checks++; if (load_err !== 1'b0)   begin errors++; $display("FAIL rst_load_err got %b want 0", load_err); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int w0, d0, t;
    w0 = wn; d0 = done_cnt;
    start_load();
    checks++; if ({cpu_hold, busy, in_ready} !== 3'b111) begin errors++; $display("FAIL start_flags got %b want 111", {cpu_hold, busy, in_ready}); end
    send_byte(8'd2, 1'b0);
    send_word(32'h12345678, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    finish_load();
    wait_done(t);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL basic_hold_in_done got %b want 1", cpu_hold); end
    @(negedge clk);
    checks++; if ({cpu_hold, busy, load_done} !== 3'b000) begin errors++; $display("FAIL basic_release got %b want 000", {cpu_hold, busy, load_done}); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d want 1", done_cnt - d0); end
    checks++; if (wn - w0 !== 2) begin errors++; $display("FAIL basic_writes got %0d want 2", wn - w0); end
    checks++; if (wa[w0] !== 32'd0 || wd[w0] !== 32'h12345678) begin errors++; $display("FAIL basic_w0 got %h@%h want 12345678@0", wd[w0], wa[w0]); end
    checks++; if (wa[w0+1] !== 32'd1 || wd[w0+1] !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_w1 got %h@%h want deadbeef@1", wd[w0+1], wa[w0+1]); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", load_err); end
  endtask

  task automatic test_zero();
    int w0, t, extra;
    w0 = wn;
    start_load();
    send_byte(8'd0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    extra = 0;
    finish_load();
`else
    extra = 1;
    idle_bus();
    checks++; if ({in_ready, load_done} !== 2'b00) begin errors++; $display("FAIL zero_check_state got %b want 00", {in_ready, load_done}); end
`endif
    wait_done(t);
    checks++; if (t + extra < 1 || t + extra > 2) begin errors++; $display("FAIL zero_latency got %0d want 1..2", t + extra); end
    @(negedge clk);
    checks++; if (wn - w0 !== 0) begin errors++; $display("FAIL zero_writes got %0d want 0", wn - w0); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL zero_err got %b want 0", load_err); end
  endtask

  task automatic test_toggle();
    int w0, t;
    w0 = wn;
    start_load();
    send_byte(8'd1, 1'b1);
    send_word(32'hD4C3B2A1, 1'b1);
    finish_load();
    wait_done(t);
    @(negedge clk);
    checks++; if (wn - w0 !== 1) begin errors++; $display("FAIL toggle_writes got %0d want 1", wn - w0); end
    checks++; if (wa[w0] !== 32'd0 || wd[w0] !== 32'hD4C3B2A1) begin errors++; $display("FAIL toggle_w0 got %h@%h want d4c3b2a1@0", wd[w0], wa[w0]); end
    checks++; if ({load_err, busy} !== 2'b00) begin errors++; $display("FAIL toggle_end got %b want 00", {load_err, busy}); end
  endtask

  task automatic test_overflow();
    int w0, t;
    w0 = wn;
    start_load();
    send_byte(8'd33, 1'b0);
    #1;
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL ovf_err_after_header got %b want 1", load_err); end
    for (int i = 0; i < 33; i++) send_word({8'h80, 8'h00, 8'h5A, 8'(i)}, 1'b0);
    finish_load();
    wait_done(t);
    @(negedge clk);
    checks++; if (wn - w0 !== 33) begin errors++; $display("FAIL ovf_writes got %0d want 33", wn - w0); end
    checks++; if (wa[w0+31] !== 32'd31) begin errors++; $display("FAIL ovf_addr31 got %h want 1f", wa[w0+31]); end
    checks++; if (wa[w0+32] !== 32'd0 || wd[w0+32] !== 32'h80005A20) begin errors++; $display("FAIL ovf_w32 got %h@%h want 80005a20@0", wd[w0+32], wa[w0+32]); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL ovf_err_end got %b want 1", load_err); end
  endtask

  task automatic test_reset_mid();
    int w0, t;
    w0 = wn;
    start_load();
    send_byte(8'd2, 1'b0);
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    #2;
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++; if ({in_ready, mem_we, cpu_hold, busy, load_done, load_err} !== 6'b0) begin errors++; $display("FAIL mid_rst_flags got %b want 000000", {in_ready, mem_we, cpu_hold, busy, load_done, load_err}); end
    checks++; if (mem_waddr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL mid_rst_bus got %h/%h want 0/0", mem_waddr, mem_wdata); end
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (wn - w0 !== 1) begin errors++; $display("FAIL mid_rst_writes got %0d want 1", wn - w0); end
    checks++; if (wd[w0] !== 32'hCAFEF00D) begin errors++; $display("FAIL mid_rst_w0 got %h want cafef00d", wd[w0]); end
    start_load();
    send_byte(8'd1, 1'b0);
    send_word(32'h44332211, 1'b0);
    finish_load();
    wait_done(t);
    @(negedge clk);
    checks++; if (wn - w0 !== 2) begin errors++; $display("FAIL relaod_writes got %0d want 2", wn - w0); end
    checks++; if (wa[w0+1] !== 32'd0 || wd[w0+1] !== 32'h44332211) begin errors++; $display("FAIL reload_w got %h@%h want 44332211@0", wd[w0+1], wa[w0+1]); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    int t;
    for (int k = 0; k < 2; k++) begin
      start_load();
      send_byte(8'd1, 1'b0);
      send_word(32'h04030201, 1'b0);
      send_byte((k == 0) ? 8'h04 : 8'h05, 1'b0);
      idle_bus();
      wait_done(t);
      checks++; if (load_err !== 1'(k)) begin errors++; $display("FAIL csum_err case=%0d got %b want %0d", k, load_err, k); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_toggle();
    test_overflow();
    test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
